// File: rtl/alu_seq_pkg.sv
// alu_seq shared control encodings: ALU opcodes and sequencer states.
// Base and RV32M operation codes live side by side here.
package alu_seq_pkg;

    localparam int ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'd9;
    localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'd16;
    localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'd17;
    localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'd18;
    localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'd19;
    localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'd20;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'd21;
    localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'd22;
    localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// done stays high from the last iteration until the cycle after.
module alu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN:0]    trial;

    // Borrow out of the trial subtraction means "restore"
    assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
        end else if (abort) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            cnt_q    <= CNT_W'(XLEN);
            active_q <= 1'b1;
            quo_q    <= dividend;
            rem_q    <= '0;
            dvs_q    <= divisor;
        end else if (active_q) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
                if (!trial[XLEN]) begin
                    rem_q <= trial[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_q <= {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                    quo_q <= {quo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign done      = active_q && (cnt_q == '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute ALU: base ops, RV32M multiply/divide,
// valid/ready on both sides and a registered result.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic                alu_src,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    input  logic [XLEN-1:0]     imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                zero,
    output logic                busy
);

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_e          state_q;
    logic [XLEN-1:0]     result_q;
    logic                zero_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [ALU_OP_W-1:0] op_q;
    logic [XLEN-1:0]     op1_q;
    logic [XLEN-1:0]     op2_q;
    logic                negq_q;
    logic                negr_q;

    function automatic logic [XLEN-1:0] base_op(
        input logic [ALU_OP_W-1:0] o,
        input logic [XLEN-1:0]     a,
        input logic [XLEN-1:0]     b
    );
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        case (o)
            ALU_ADD:  base_op = a + b;
            ALU_SUB:  base_op = a - b;
            ALU_AND:  base_op = a & b;
            ALU_OR:   base_op = a | b;
            ALU_XOR:  base_op = a ^ b;
            ALU_SLT:  base_op = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: base_op = {{(XLEN-1){1'b0}}, a < b};
            ALU_SLL:  base_op = a << sh;
            ALU_SRL:  base_op = a >> sh;
            ALU_SRA:  base_op = $unsigned($signed(a) >>> sh);
            default:  base_op = '0;
        endcase
    endfunction

    logic [XLEN-1:0] op2;
    logic            is_mul, is_div, div_sgn, is_rem;
    logic            s1, s2, div_zero, div_ovf, special;
    logic            accept, div_start;
    logic [XLEN-1:0] mag1, mag2, spec_res, result_d;

    assign op2      = alu_src ? imm : src2;
    assign in_ready = (state_q == ST_IDLE) ||
                      (state_q == ST_DONE && out_ready);
    assign accept   = in_valid && in_ready && !flush;

    assign is_mul   = (op[4:2] == 3'b100);
    assign is_div   = (op[4:2] == 3'b101);
    assign div_sgn  = !op[0];
    assign is_rem   = op[1];
    assign s1       = div_sgn && src1[XLEN-1];
    assign s2       = div_sgn && op2[XLEN-1];
    assign mag1     = s1 ? -src1 : src1;
    assign mag2     = s2 ? -op2 : op2;
    assign div_zero = (op2 == '0);
    assign div_ovf  = div_sgn && (src1 == SMIN) && (op2 == '1);
    assign special  = is_div && (div_zero || div_ovf);

    // Division special cases bypass the iterative core entirely
    assign spec_res = div_zero ? (is_rem ? src1 : '1)
                               : (is_rem ? '0 : src1);
    assign result_d = special ? spec_res
                    : is_mul  ? '0
                    : base_op(op, src1, op2);
    assign div_start = accept && is_div && !special;

    logic            div_done;
    logic [XLEN-1:0] quo, rem, div_res;

    alu_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (flush),
        .dividend  (mag1),
        .divisor   (mag2),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    assign div_res = op_q[1] ? (negr_q ? -rem : rem)
                             : (negq_q ? -quo : quo);

    logic              msg1, msg2;
    logic [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN-1:0]   mul_res;

    assign msg1    = (op_q == ALU_MULH) || (op_q == ALU_MULHSU);
    assign msg2    = (op_q == ALU_MULH);
    assign ma      = {{XLEN{msg1 && op1_q[XLEN-1]}}, op1_q};
    assign mb      = {{XLEN{msg2 && op2_q[XLEN-1]}}, op2_q};
    assign prod    = ma * mb;
    assign mul_res = (op_q == ALU_MUL) ? prod[XLEN-1:0]
                                       : prod[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_q   <= op;
                        op1_q  <= src1;
                        op2_q  <= op2;
                        negq_q <= s1 ^ s2;
                        negr_q <= s1;
                        if (is_mul) begin
                            state_q     <= ST_MUL;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else if (div_start) begin
                            state_q     <= ST_DIV;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= ST_DONE;
                            result_q    <= result_d;
                            zero_q      <= (result_d == '0);
                            out_valid_q <= 1'b1;
                        end
                    end else if (state_q == ST_DONE && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_MUL: begin
                    state_q     <= ST_DONE;
                    result_q    <= mul_res;
                    zero_q      <= (mul_res == '0);
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_q     <= ST_DONE;
                        result_q    <= div_res;
                        zero_q      <= (div_res == '0);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a cycle-level reference model
// checked on every falling edge.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush, in_valid, alu_src, out_ready;
    logic [4:0]  op;
    logic [31:0] src1, src2, imm;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .alu_src   (alu_src),
        .src1      (src1),
        .src2      (src2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endfunction

    function automatic void chk1(string n, logic act, logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endfunction

    // Reference semantics straight from the ISA rules
    function automatic logic [31:0] model(input logic [4:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (o)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_XOR:    return a ^ b;
            ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
            ALU_SLL:    return a << b[4:0];
            ALU_SRL:    return a >> b[4:0];
            ALU_SRA:    return 32'(sa >>> b[4:0]);
            ALU_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
            ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            ALU_MULHSU: begin p = 64'(sa * ua); return p[63:32]; end
            ALU_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (sa == -64'sd2147483648 && sb == -1) return a;
                return 32'(sa / sb);
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (sa == -64'sd2147483648 && sb == -1) return 32'd0;
                return 32'(sa % sb);
            end
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] o,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (o >= ALU_MUL && o <= ALU_MULHU) return 2;
        if (o >= ALU_DIV && o <= ALU_REMU) begin
            if (b == 0) return 1;
            if ((o == ALU_DIV || o == ALU_REM) &&
                a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 34;
        end
        return 1;
    endfunction

    typedef struct {
        int          acc;
        int          lat;
        logic [31:0] res;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic        ov = 1'b0;
    logic        irdy;
    logic [31:0] cur_res;
    logic [31:0] b2;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_result", result, 32'd0);
            chk1("rst_zero", zero, 1'b0);
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_in_ready", in_ready, 1'b1);
            q.delete();
            ov = 1'b0;
        end else begin
            if (q.size() > 0 && (cyc - q[0].acc) >= q[0].lat) begin
                e = q.pop_front();
                chk1("out_valid_rise", out_valid, 1'b1);
                chk("result", result, e.res);
                chk1("zero", zero, e.res == 32'd0);
                ov = 1'b1;
                cur_res = e.res;
            end else begin
                chk1("out_valid", out_valid, ov);
                if (ov) begin
                    chk("held_result", result, cur_res);
                    chk1("held_zero", zero, cur_res == 32'd0);
                end
            end
            chk1("busy", busy, q.size() > 0 && q[0].lat > 1);
            irdy = (q.size() == 0) && (!ov || out_ready);
            chk1("in_ready", in_ready, irdy);
            if (in_valid && irdy && !flush) begin
                b2 = alu_src ? imm : src2;
                q.push_back('{acc: cyc, lat: model_lat(op, src1, b2),
                              res: model(op, src1, b2)});
            end
            if (ov && out_ready) ov = 1'b0;
            if (flush) begin
                q.delete();
                ov = 1'b0;
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic s,
                         input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] lit);
        bit ok;
        chk("model_pin", model(o, a, s ? im : r2), lit);
        op = o;
        alu_src = s;
        src1 = a;
        src2 = r2;
        imm = im;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            nerr++;
            $display("FAIL accept_timeout: in_ready low for 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1 = $urandom;
        src2 = $urandom;
        imm = $urandom;
    endtask

    task automatic wait_out(output int lat, output int nb);
        lat = 0;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (busy) nb++;
            if (out_valid) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int l, nb;

    initial begin
        flush = 1'b0;
        in_valid = 1'b0;
        alu_src = 1'b0;
        out_ready = 1'b1;
        op = '0;
        src1 = '0;
        src2 = '0;
        imm = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(ALU_ADD, 1'b1, 32'd5, 32'd100, 32'hFFFF_FFFD, 32'd2);
        issue(ALU_SRA, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000);
        wait_out(l, nb);
        chk("sra_lat", l, 1);

        issue(ALU_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
        issue(ALU_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        issue(ALU_SLL, 1'b0, 32'd1, 32'd63, 32'd0, 32'h8000_0000);
        issue(ALU_SRL, 1'b0, 32'h8000_0000, 32'd31, 32'd0, 32'd1);
        issue(ALU_XOR, 1'b1, 32'hF0F0_0F0F, 32'd0, 32'hFFFF_0000, 32'h0F0F_0F0F);
        issue(ALU_AND, 1'b0, 32'hF0F0_0F0F, 32'h0FF0_0FF0, 32'd0, 32'h00F0_0F00);
        issue(ALU_OR, 1'b0, 32'hF000_0000, 32'h0000_000F, 32'd0, 32'hF000_000F);
        issue(5'd10, 1'b0, 32'd7, 32'd9, 32'd0, 32'd0);
        wait_out(l, nb);

        issue(ALU_MULH, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF);
        wait_out(l, nb);
        chk("mulh_lat", l, 2);
        chk("mulh_busy", nb, 1);
        issue(ALU_MULHU, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1);
        wait_out(l, nb);
        chk("mulhu_lat", l, 2);
        issue(ALU_MULHSU, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF);
        issue(ALU_MUL, 1'b0, 32'h0001_0001, 32'h0001_0001, 32'd0, 32'h0002_0001);
        wait_out(l, nb);

        issue(ALU_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFD);
        wait_out(l, nb);
        chk("div_lat", l, 34);
        chk("div_busy", nb, 33);
        issue(ALU_REM, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFF);
        wait_out(l, nb);
        chk("rem_lat", l, 34);
        issue(ALU_DIVU, 1'b0, 32'd100, 32'd7, 32'd0, 32'd14);
        issue(ALU_REMU, 1'b0, 32'd100, 32'd7, 32'd0, 32'd2);
        wait_out(l, nb);

        issue(ALU_DIVU, 1'b0, 32'd9, 32'd0, 32'd0, 32'hFFFF_FFFF);
        wait_out(l, nb);
        chk("divz_lat", l, 1);
        issue(ALU_REM, 1'b0, 32'd9, 32'd0, 32'd0, 32'd9);
        issue(ALU_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        issue(ALU_REM, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        wait_out(l, nb);
        chk("ovf_lat", l, 1);
        chk1("ovf_zero", zero, 1'b1);

        issue(ALU_DIV, 1'b0, 32'd100, 32'd7, 32'd0, 32'd14);
        cycles(9);
        flush = 1'b1;
        in_valid = 1'b1;
        op = ALU_ADD;
        alu_src = 1'b0;
        src1 = 32'd1;
        src2 = 32'd1;
        cycles(1);
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk1("flush_valid", out_valid, 1'b0);
        chk1("flush_busy", busy, 1'b0);
        chk1("flush_in_ready", in_ready, 1'b1);
        repeat (40) @(negedge clk);
        cycles(1);
        issue(ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 32'd2);
        wait_out(l, nb);
        chk("flush_add_lat", l, 1);

        issue(ALU_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFD);
        cycles(10);
        rst_n = 1'b0;
        #1;
        chk("arst_result", result, 32'd0);
        chk1("arst_valid", out_valid, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_in_ready", in_ready, 1'b1);
        cycles(2);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        cycles(1);
        issue(ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 32'd2);
        wait_out(l, nb);
        chk("rst_add_lat", l, 1);

        out_ready = 1'b0;
        issue(ALU_SUB, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result", result, 32'd0);
            chk1("bp_zero", zero, 1'b1);
            chk1("bp_valid", out_valid, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("bp_consumed", out_valid, 1'b0);

        cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares", nerr);
        $fatal(1);
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the single-cycle execute ALU. It adds the RV32M multiply/divide operations alongside the base integer operations and wraps every operation in valid/ready handshakes, so execute can stall on long-latency operations. It sits in the execute stage between operand selection and writeback, and runs one operation at a time.

## Interface
**Parameters**
- `XLEN`, default 32: operand/result width; must be ≥ 8 and a power of 2.
- `SHAMT_W`, default $clog2(XLEN): shift-amount width.

**Ports** (name, direction, width, meaning)
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous abort of the in-flight operation.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request.
- `op` in 5: operation code.
- `alu_src` in 1: 1 selects `imm` as operand 2, 0 selects `src2`.
- `src1` in XLEN: operand 1.
- `src2` in XLEN: register operand 2.
- `imm` in XLEN: sign-extended immediate.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: consumer takes the result.
- `result` out XLEN: registered result.
- `zero` out 1: registered (result == 0).
- `busy` out 1: multiply or divide in progress.

## Operation
- **Opcodes:**
  - base ops: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
  - M ops: MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
  - Any other code gives result 0 with base-op latency.
- **Operand 2:** op2 = alu_src ? imm : src2, sampled only on the accept edge. Inputs may change after acceptance.
- **Shifts:** use op2[SHAMT_W-1:0]. SRA is arithmetic.
- **Compares:** SLT/SLTU produce zero-extended 0/1.
- **Multiply:** MUL returns the low XLEN bits of the 2·XLEN product. MULH returns the high half of signed×signed, MULHSU of signed×unsigned, MULHU of unsigned×unsigned.
- **Divide:** restoring, unsigned core on magnitudes; signs are fixed up afterwards. Quotient truncates toward zero; remainder takes the dividend's sign.
- **Divide by zero:** quotient is all-ones; remainder is the dividend.
- **Signed overflow** (dividend = −2^(XLEN−1), divisor = −1): quotient is the dividend; remainder is 0.
- **State machine:**
  - IDLE: the accept leads to DONE for base ops and the divide special cases, to MUL for MUL*, and to DIV for DIV/REM.
  - MUL: goes to DONE after 1 cycle.
  - DIV: iterates XLEN cycles, then one sign-fix cycle, then goes to DONE.
  - DONE: out_valid=1; returns to IDLE on out_ready.
- **Handshake:**
  - Accept = in_valid && in_ready, with in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back operations are possible.
  - result, zero and out_valid hold stable while out_valid && !out_ready.
- **busy:** equals (state==MUL || state==DIV).

## Timing
- **Reset** (async assert, sync-free deassert): state=IDLE; result=0; zero=0; out_valid=0; busy=0; counters=0. in_ready=1 immediately.
- **Latency**, measured from the accept edge to the first cycle with out_valid=1:
  - base ops: 1 cycle.
  - MUL*: 2 cycles.
  - DIV/REM: XLEN+2 cycles (34 for XLEN=32).
  - divide special cases: 1 cycle.
- **Throughput:** base ops sustain 1/cycle while out_ready=1.
- **Flush:**
  - On the next edge: state→IDLE, out_valid=0, busy=0, in-flight operation discarded.
  - Flush wins over a same-cycle accept; that request is not taken.
  - result/zero keep their stale values.
- **Reset mid-divide:** the operation is lost, with no partial result visible.
- **Output stall:** out_ready=0 in DONE holds the block indefinitely, with in_ready=0.

## Structure
- **Shared control header:** add the 5-bit opcode defines and the `ALU_OP_W`=5 constant to the shared control-encoding header, next to the existing ALU control codes.
- **`alu_divider` sub-module** (iterative restoring unsigned divider):
  - ports: clk, rst_n, start, abort, dividend, divisor, done, quotient, remainder.
  - XLEN-cycle loop using a $clog2(XLEN)+1-bit counter.
- **`alu_seq` top level:** sign handling, special-case shortcut, multiplier register stage, FSM, output register.

## Test plan
- **ADD then SRA back-to-back:** ADD src1=5, imm=−3, alu_src=1, then SRA src1=0x80000000, src2=4, with out_ready=1. Expect result=2 one cycle after the first accept, then 0xF8000000 on the next cycle; in_ready stays 1.
- **MULH/MULHU:** src1=0xFFFFFFFF, src2=2. MULH → 0xFFFFFFFF and MULHU → 0x00000001, each with out_valid 2 cycles after accept.
- **Signed divide:** DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF. out_valid 34 cycles after accept; busy high for exactly 33 cycles; in_ready=0 meanwhile.
- **Divide special cases:** DIVU 9/0 → 0xFFFFFFFF; REM 9/0 → 9; DIV 0x80000000/−1 → 0x80000000; REM → 0 with zero=1. Each has 1-cycle latency.
- **Flush and reset mid-divide:** flush asserted 10 cycles into a DIV, together with in_valid. Expect out_valid never rises for it, state returns to IDLE, and the next ADD 1+1 returns 2 with 1-cycle latency. Repeat using rst_n low mid-divide and expect all outputs 0 asynchronously.
- **Output backpressure:** hold out_ready=0 for 5 cycles after a SUB 3−3 result. result=0, zero=1 and out_valid stay stable, in_ready=0; the result is consumed on the first out_ready=1 cycle.
